// File: rtl/shared_delay_scheduler_if.sv
// Request/grant bundle between requesters and the shared delay scheduler.
interface shared_delay_scheduler_if #(
    parameter int WIDTH = 4
) ();
    logic [1:0]       req;
    logic [WIDTH-1:0] len0;
    logic [WIDTH-1:0] len1;
    logic [1:0]       gnt;
    logic [1:0]       done;
    logic             busy;
    logic [WIDTH-1:0] count;

    modport master (
        output req, len0, len1,
        input  gnt, done, busy, count
    );

    modport slave (
        input  req, len0, len1,
        output gnt, done, busy, count
    );
endinterface

// File: rtl/shared_delay_scheduler.sv
// Two requesters share one down counter; round-robin grant, fixed L+1 latency to done.
//   state | meaning
//   IDLE  | counter free, arbitrate pending requests
//   RUN   | owner holds counter, counting down to zero
//   DONE  | one-cycle done pulse to owner, then release
module shared_delay_scheduler #(
    parameter int WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    shared_delay_scheduler_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [1:0]       gnt_q, gnt_d;
    logic [1:0]       done_q, done_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             last_q, last_d;
    logic             owner;
    logic             win;

    assign owner     = gnt_q[1];
    assign bus.gnt   = gnt_q;
    assign bus.done  = done_q;
    assign bus.count = count_q;
    assign bus.busy  = (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= 2'b00;
            done_q  <= 2'b00;
            count_q <= {WIDTH{1'b1}};
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            count_q <= count_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        done_d  = 2'b00;
        count_d = count_q;
        last_d  = last_q;
        win     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req != 2'b00) begin
                    // On a tie the requester not served last time wins
                    win     = (bus.req == 2'b11) ? ~last_q : bus.req[1];
                    gnt_d   = win ? 2'b10 : 2'b01;
                    count_d = win ? bus.len1 : bus.len0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!bus.req[owner]) begin
                    state_d = IDLE;
                    gnt_d   = 2'b00;
                    last_d  = owner;
                end else if (count_q == '0) begin
                    state_d = DONE;
                    done_d  = gnt_q;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                gnt_d   = 2'b00;
                last_d  = owner;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 2'b00;
            end
        endcase
    end
endmodule

// File: tb/tb_shared_delay_scheduler.sv
// Self-checking bench for shared_delay_scheduler: vector table plus corner-case sequences.
module tb_shared_delay_scheduler;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    shared_delay_scheduler_if #(.WIDTH(4)) bus ();

    shared_delay_scheduler #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic       rst_n;
        logic [1:0] req;
        logic [3:0] l0;
        logic [3:0] l1;
        logic [1:0] gnt;
        logic [1:0] done;
        logic       busy;
        logic [3:0] cnt;
    } vec_t;

    typedef struct {
        logic [1:0] gnt;
        logic [1:0] done;
        logic       busy;
        logic [3:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Drive one cycle of inputs, queue the expected post-edge outputs, then check them.
    task automatic step(input string name, input logic r, input logic [1:0] rq,
                        input logic [3:0] a, input logic [3:0] b,
                        input logic [1:0] eg, input logic [1:0] ed,
                        input logic eb, input logic [3:0] ec);
        exp_t e;
        rst_n    = r;
        bus.req  = rq;
        bus.len0 = a;
        bus.len1 = b;
        e.gnt = eg; e.done = ed; e.busy = eb; e.cnt = ec;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        n_cmp++;
        if (bus.gnt !== e.gnt || bus.done !== e.done || bus.busy !== e.busy || bus.count !== e.cnt) begin
            n_bad++;
            $display("FAIL %s: got gnt=%b done=%b busy=%b count=%0d, expected gnt=%b done=%b busy=%b count=%0d",
                     name, bus.gnt, bus.done, bus.busy, bus.count, e.gnt, e.done, e.busy, e.cnt);
        end
    endtask

    vec_t tbl[27];

    initial begin
        int  done_at;
        bit  seen;
        logic [3:0] first_cnt;

        // rst, req, len0, len1 | gnt, done, busy, count
        tbl[0]  = '{1'b0, 2'b00, 4'd0, 4'd0, 2'b00, 2'b00, 1'b0, 4'hF};
        tbl[1]  = '{1'b1, 2'b00, 4'd0, 4'd0, 2'b00, 2'b00, 1'b0, 4'hF};
        tbl[2]  = '{1'b1, 2'b01, 4'd3, 4'd0, 2'b01, 2'b00, 1'b1, 4'd3};
        tbl[3]  = '{1'b1, 2'b01, 4'd3, 4'd0, 2'b01, 2'b00, 1'b1, 4'd2};
        tbl[4]  = '{1'b1, 2'b01, 4'd3, 4'd0, 2'b01, 2'b00, 1'b1, 4'd1};
        tbl[5]  = '{1'b1, 2'b01, 4'd3, 4'd0, 2'b01, 2'b00, 1'b1, 4'd0};
        tbl[6]  = '{1'b1, 2'b01, 4'd3, 4'd0, 2'b01, 2'b01, 1'b1, 4'd0};
        tbl[7]  = '{1'b1, 2'b00, 4'd3, 4'd0, 2'b00, 2'b00, 1'b0, 4'd0};
        tbl[8]  = '{1'b1, 2'b00, 4'd3, 4'd0, 2'b00, 2'b00, 1'b0, 4'd0};
        tbl[9]  = '{1'b1, 2'b10, 4'd5, 4'd0, 2'b10, 2'b00, 1'b1, 4'd0};
        tbl[10] = '{1'b1, 2'b10, 4'd5, 4'd0, 2'b10, 2'b10, 1'b1, 4'd0};
        tbl[11] = '{1'b1, 2'b00, 4'd5, 4'd0, 2'b00, 2'b00, 1'b0, 4'd0};
        tbl[12] = '{1'b0, 2'b11, 4'd1, 4'd2, 2'b00, 2'b00, 1'b0, 4'hF};
        tbl[13] = '{1'b1, 2'b11, 4'd1, 4'd2, 2'b01, 2'b00, 1'b1, 4'd1};
        tbl[14] = '{1'b1, 2'b11, 4'd1, 4'd2, 2'b01, 2'b00, 1'b1, 4'd0};
        tbl[15] = '{1'b1, 2'b11, 4'd1, 4'd2, 2'b01, 2'b01, 1'b1, 4'd0};
        tbl[16] = '{1'b1, 2'b11, 4'd1, 4'd2, 2'b00, 2'b00, 1'b0, 4'd0};
        tbl[17] = '{1'b1, 2'b11, 4'd1, 4'd2, 2'b10, 2'b00, 1'b1, 4'd2};
        tbl[18] = '{1'b1, 2'b11, 4'd1, 4'd2, 2'b10, 2'b00, 1'b1, 4'd1};
        tbl[19] = '{1'b1, 2'b11, 4'd1, 4'd2, 2'b10, 2'b00, 1'b1, 4'd0};
        tbl[20] = '{1'b1, 2'b11, 4'd1, 4'd2, 2'b10, 2'b10, 1'b1, 4'd0};
        tbl[21] = '{1'b1, 2'b11, 4'd1, 4'd2, 2'b00, 2'b00, 1'b0, 4'd0};
        tbl[22] = '{1'b1, 2'b11, 4'd1, 4'd2, 2'b01, 2'b00, 1'b1, 4'd1};
        tbl[23] = '{1'b1, 2'b00, 4'd1, 4'd2, 2'b00, 2'b00, 1'b0, 4'd1};
        tbl[24] = '{1'b1, 2'b00, 4'd1, 4'd2, 2'b00, 2'b00, 1'b0, 4'd1};
        tbl[25] = '{1'b1, 2'b01, 4'd0, 4'd7, 2'b01, 2'b00, 1'b1, 4'd0};
        tbl[26] = '{1'b1, 2'b00, 4'd0, 4'd7, 2'b00, 2'b00, 1'b0, 4'd0};

        rst_n    = 1'b0;
        bus.req  = 2'b00;
        bus.len0 = 4'd0;
        bus.len1 = 4'd0;

        for (int i = 0; i < 27; i++) begin
            step($sformatf("vec%0d", i), tbl[i].rst_n, tbl[i].req, tbl[i].l0, tbl[i].l1,
                 tbl[i].gnt, tbl[i].done, tbl[i].busy, tbl[i].cnt);
        end

        // Abort at count 5 with requester 1 pending
        step("abort_grant",  1'b1, 2'b01, 4'd9, 4'd7, 2'b01, 2'b00, 1'b1, 4'd9);
        step("abort_cnt8",   1'b1, 2'b11, 4'd9, 4'd7, 2'b01, 2'b00, 1'b1, 4'd8);
        step("abort_cnt7",   1'b1, 2'b11, 4'd9, 4'd7, 2'b01, 2'b00, 1'b1, 4'd7);
        step("abort_cnt6",   1'b1, 2'b11, 4'd9, 4'd7, 2'b01, 2'b00, 1'b1, 4'd6);
        step("abort_cnt5",   1'b1, 2'b11, 4'd9, 4'd7, 2'b01, 2'b00, 1'b1, 4'd5);
        step("abort_drop",   1'b1, 2'b10, 4'd9, 4'd7, 2'b00, 2'b00, 1'b0, 4'd5);
        step("abort_next",   1'b1, 2'b10, 4'd9, 4'd7, 2'b10, 2'b00, 1'b1, 4'd7);
        step("abort_rel",    1'b1, 2'b00, 4'd9, 4'd7, 2'b00, 2'b00, 1'b0, 4'd7);

        // Reset while running at count 6
        step("rst_grant",    1'b1, 2'b01, 4'd8, 4'd3, 2'b01, 2'b00, 1'b1, 4'd8);
        step("rst_cnt7",     1'b1, 2'b01, 4'd8, 4'd3, 2'b01, 2'b00, 1'b1, 4'd7);
        step("rst_cnt6",     1'b1, 2'b01, 4'd8, 4'd3, 2'b01, 2'b00, 1'b1, 4'd6);
        step("rst_midrun",   1'b0, 2'b01, 4'd6, 4'd3, 2'b00, 2'b00, 1'b0, 4'hF);
        step("rst_resume",   1'b1, 2'b11, 4'd6, 4'd3, 2'b01, 2'b00, 1'b1, 4'd6);
        step("rst_rel",      1'b1, 2'b00, 4'd6, 4'd3, 2'b00, 2'b00, 1'b0, 4'd6);

        // Reset landing in DONE suppresses the pulse
        step("rdone_grant",  1'b1, 2'b10, 4'd6, 4'd0, 2'b10, 2'b00, 1'b1, 4'd0);
        step("rdone_done",   1'b1, 2'b10, 4'd6, 4'd0, 2'b10, 2'b10, 1'b1, 4'd0);
        step("rdone_rst",    1'b0, 2'b10, 4'd6, 4'd0, 2'b00, 2'b00, 1'b0, 4'hF);
        step("rdone_idle",   1'b1, 2'b00, 4'd6, 4'd0, 2'b00, 2'b00, 1'b0, 4'hF);

        // len0 changed after grant must not alter the L=4 timing
        step("len_grant",    1'b1, 2'b01, 4'd4, 4'd0, 2'b01, 2'b00, 1'b1, 4'd4);
        bus.len0  = 4'd12;
        seen      = 1'b0;
        done_at   = 0;
        first_cnt = 4'hx;
        for (int k = 1; k <= 16 && !seen; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) first_cnt = bus.count;
            if (bus.done == 2'b01) begin
                seen    = 1'b1;
                done_at = k;
            end
        end
        n_cmp++;
        if (first_cnt !== 4'd3) begin
            n_bad++;
            $display("FAIL len_first_count: got %0d, expected 3", first_cnt);
        end
        n_cmp++;
        if (!seen || done_at != 5) begin
            n_bad++;
            $display("FAIL len_done_edge: got edge %0d (seen=%0b), expected edge 5", done_at, seen);
        end
        step("len_rel",      1'b1, 2'b00, 4'd12, 4'd0, 2'b00, 2'b00, 1'b0, 4'd0);

        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d left, expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/shared_delay_scheduler.md
SHARED_DELAY_SCHEDULER -- requirements
Module: shared_delay_scheduler

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, setting the width of the delay length and of the counter.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port req, input, 2 bits: level request per requester i (0,1), held high until done[i] or abandoned.
REQ-005 The block SHALL have port len0, input, WIDTH bits: delay length for requester 0, sampled only at grant.
REQ-006 The block SHALL have port len1, input, WIDTH bits: delay length for requester 1, sampled only at grant.
REQ-007 The block SHALL have port gnt, output, 2 bits, registered: one-hot owner of the shared down counter; 2'b00 when free.
REQ-008 The block SHALL have port done, output, 2 bits, registered: one-cycle completion pulse to the owner.
REQ-009 The block SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-010 The block SHALL have port count, output, WIDTH bits, registered: current value of the shared down counter.

Function
REQ-011 The block SHALL implement exactly the states IDLE, RUN and DONE.
REQ-012 In IDLE with req != 0, the block SHALL select a winner at the clock edge, set gnt to the winner, load count with that winner's len, and go to RUN.
REQ-013 Arbitration SHALL be round-robin: with both req bits high in IDLE, the requester not recorded in last_served SHALL win; with one bit high, that requester SHALL win.
REQ-014 In RUN with count != 0 and the owner's req high, count SHALL decrement by 1 per cycle with no wrap.
REQ-015 In RUN with count == 0 and the owner's req high, the block SHALL go to DONE and set done[owner] = 1.
REQ-016 In DONE, the block SHALL go to IDLE on the next edge, clear done and gnt, and set last_served = owner.
REQ-017 Latency SHALL be fixed: for a grant edge E0 with length L, done is high for exactly the one cycle following edge E0+L+1, including L = 0 (done after E0+1).
REQ-018 Abort: in RUN, if the owner's req is low at an edge, the block SHALL go to IDLE, clear gnt, leave done low, set last_served = owner, and hold count at its current value.
REQ-019 The non-owner's req SHALL be ignored in RUN and DONE; it stays pending and is arbitrated on the first IDLE edge.
REQ-020 In IDLE with req == 0, count SHALL hold its value.
REQ-021 len0 and len1 changes after the grant edge SHALL have no effect on the current operation.
REQ-022 A requester still holding req in the IDLE cycle after its done pulse SHALL be treated as a new request under REQ-013.
REQ-023 There SHALL be no back-to-back grant from DONE: at least one IDLE cycle always separates operations.

Reset
REQ-024 While rst_n is low at a rising edge, the block SHALL set state = IDLE, gnt = 2'b00, done = 2'b00, count = all ones (4'b1111 at WIDTH = 4), and last_served = 1.
REQ-025 Reset SHALL override all other activity, including mid-RUN and DONE, with no done pulse; operation SHALL resume on the first edge with rst_n high.
REQ-026 Reset SHALL have no asynchronous effect: outputs change only at clock edges.

Verification
REQ-027 The bench SHALL check single request: req = 2'b01, len0 = 3 -> gnt = 01, count goes 3,2,1,0, then done = 01 for one cycle, then IDLE with busy = 0.
REQ-028 The bench SHALL check the tie after reset: req = 2'b11 -> first gnt = 01; after its done, with both still high, next gnt = 10 (alternation continues).
REQ-029 The bench SHALL check zero length: req = 2'b10, len1 = 0 -> gnt = 10, count = 0, done = 10 one cycle later (edge E0+1).
REQ-030 The bench SHALL check abort: req0 grant with len0 = 9, drop req[0] when count = 5 -> gnt = 00, no done pulse, count holds 5, pending req[1] granted next IDLE edge.
REQ-031 The bench SHALL check reset mid-RUN: rst_n low for one edge while count = 6 -> gnt = 00, done = 00, count = 4'b1111, busy = 0; then req = 2'b11 -> gnt = 01.
REQ-032 The bench SHALL check len change: change len0 from 4 to 12 one cycle after grant -> completion timing still follows L = 4.
